sdf_r2_stage_ctrl: RTL
======================

# sdf_r2_stage_ctrl

Sequencer for one radix-2 single-path-delay-feedback (SDF) FFT stage. Drives the 2-bit stage-state code of the stage's radix-2 butterfly, the shift-enable of its DEPTH-entry feedback delay line, and the twiddle index for the twiddle ROM. It gates the upstream sample stream with a ready/valid handshake. One instance sits beside each butterfly/delay-line pair in the 32-point pipeline.

## Interface
Parameters:
- DEPTH, 16: delay-line length (N/2 for this stage); power of two, ≥2.
- IDX_W, $clog2(DEPTH): width of the counter and twiddle index.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  stage enable; level-sensitive, sampled on exit from IDLE and at end of frame.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  stage accepts a sample this cycle.
- bf_state  out  2  butterfly state code: IDLE=00, FIRST=01, SECOND=10, WAITING=11.
- sr_en  out  1  delay-line shift enable.
- tw_idx  out  IDX_W  twiddle index W^k; valid only in SECOND.
- out_valid  out  1  butterfly output is a valid sample this cycle.
- frame_done  out  1  one-cycle pulse on the last SECOND cycle.

## Operation
- FSM register `state` (IDLE, WAITING, FIRST, SECOND); counter `cnt` (IDX_W bits).
- bf_state = state, registered, no combinational path from inputs.
- accept = in_valid & in_ready.
- IDLE: in_ready=0, sr_en=0. If en=1: next WAITING, cnt←0.
- WAITING: in_ready=1, sr_en=accept. The butterfly loads the input into the delay line. On accept: cnt++. On accept with cnt==DEPTH-1: next FIRST, cnt←0.
- FIRST: in_ready=1, sr_en=accept, out_valid=accept. Outputs are sums (g). The delay line takes differences. Counting and exit are as in WAITING: on accept with cnt==DEPTH-1, next SECOND, cnt←0.
- SECOND: in_ready=0, sr_en=1 every cycle, out_valid=1, tw_idx=cnt, cnt++ every cycle. At cnt==DEPTH-1: frame_done=1. Next is WAITING if en=1 (cnt←0), else IDLE.
- Stalls: in_valid=0 in WAITING/FIRST holds state, cnt and delay line (sr_en=0, out_valid=0). SECOND never stalls.
- en deasserted mid-frame: the frame completes, then the FSM goes to IDLE.
- tw_idx is forced to 0 outside SECOND.
- cnt wraps only through explicit reset-to-0 on state exit; it never free-runs past DEPTH-1.
- Frame = 2·DEPTH accepted inputs → 2·DEPTH valid outputs.

## Timing
- Reset values (async, immediate): state=IDLE, cnt=0, in_ready=0, bf_state=00, sr_en=0, tw_idx=0, out_valid=0, frame_done=0.
- Reset mid-frame aborts the frame. Partial delay-line contents are discarded by the next WAITING phase.
- IDLE→WAITING takes 1 cycle after en is seen high.
- Butterfly is combinational: out_valid coincides with the accepting cycle in FIRST. There is zero added latency from the controller.
- Unstalled frame length: 3·DEPTH cycles. Back-to-back frames (en held high) have a DEPTH-cycle input bubble during SECOND.
- in_ready and out_valid are combinational from state and in_valid only.

## Configuration
- SDF_CTRL_FRAME_CNT_EN defined: adds output frame_cnt[7:0]. Reset 0; increments on each frame_done; wraps 255→0.
- Undefined: the port and its register are absent; all other behaviour is identical.

## Structure
- Shared package fft_pkg:
  - state encodings (IDLE/FIRST/SECOND/WAITING, 2-bit), common to the butterfly and this controller;
  - stage_state_t typedef;
  - default FFT size constant (32).
- No sub-module: FSM plus one counter in a single module.

## Test plan
- Reset/idle: rst_n=0 mid-FIRST (cnt=5) → all outputs 0 immediately, bf_state=00. With en=0 the block stays in IDLE.
- Unstalled frame, DEPTH=16, en=1, in_valid=1:
  - 16 cycles bf_state=11;
  - 16 cycles bf_state=01 with out_valid=1;
  - 16 cycles bf_state=10 with tw_idx 0..15 and sr_en=1;
  - frame_done only on tw_idx=15.
- Stall: drop in_valid for 3 cycles at WAITING cnt=7 → cnt held at 7, sr_en=0, still exactly 16 accepts before FIRST.
- SECOND ignores input: in_valid=1 throughout SECOND → in_ready=0, no accepts, tw_idx still increments each cycle.
- Back-to-back vs. stop: en=1 → WAITING on the cycle after frame_done. en dropped during FIRST → frame completes, then IDLE.
- SDF_CTRL_FRAME_CNT_EN defined: 257 frames → frame_cnt=1 (wrap).

Source files
------------

// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Definitions shared by the radix-2 SDF FFT stage blocks (butterfly and
// stage controller).
//   - FFT_N               : default transform size of the pipeline (32 points)
//   - STAGE_DEPTH_DEFAULT : feedback delay length of the first stage (N/2)
//   - stage_state_t       : 2-bit butterfly stage-state code
//   - is_input_phase()    : true in the states that consume upstream samples
// -----------------------------------------------------------------------------
package fft_pkg;

  localparam int FFT_N               = 32;
  localparam int STAGE_DEPTH_DEFAULT = FFT_N / 2;

  // The encoding is shared with the butterfly datapath, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_FIRST   = 2'b01,
    ST_SECOND  = 2'b10,
    ST_WAITING = 2'b11
  } stage_state_t;

  // WAITING fills the delay line and FIRST emits sums. Both consume one
  // upstream sample per accepted cycle.
  function automatic logic is_input_phase(input stage_state_t s);
    return (s == ST_WAITING) || (s == ST_FIRST);
  endfunction

endpackage

// File: rtl/sdf_r2_stage_ctrl_if.sv
// -----------------------------------------------------------------------------
// sdf_r2_stage_ctrl_if
// Bundle between one SDF stage controller and its surroundings (upstream
// sample source, butterfly, delay line and twiddle ROM).
//
// Handshake: a sample moves from upstream into the stage on every rising clk
// edge where in_valid and in_ready are both 1. in_valid may rise or fall on
// any cycle. in_ready depends only on the controller state. Upstream must hold
// its sample while in_valid=1 and in_ready=0. out_valid has no back-pressure.
// The downstream side takes the butterfly output on every cycle where
// out_valid=1.
//
// Signals:
//   en          stage enable (level)                 master -> slave
//   in_valid    upstream sample valid                master -> slave
//   in_ready    stage accepts a sample this cycle    slave  -> master
//   bf_state    butterfly stage-state code           slave  -> master
//   sr_en       delay-line shift enable              slave  -> master
//   tw_idx      twiddle index, nonzero only in SECOND slave -> master
//   out_valid   butterfly output valid               slave  -> master
//   frame_done  pulse on the last SECOND cycle       slave  -> master
//   frame_cnt   frames completed, modulo 256         slave  -> master
//               (present only with SDF_CTRL_FRAME_CNT_EN)
//
// Modports: slave = the stage controller, master = its environment.
// -----------------------------------------------------------------------------
interface sdf_r2_stage_ctrl_if
  import fft_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
);

  logic             en;
  logic             in_valid;
  logic             in_ready;
  stage_state_t     bf_state;
  logic             sr_en;
  logic [IDX_W-1:0] tw_idx;
  logic             out_valid;
  logic             frame_done;
`ifdef SDF_CTRL_FRAME_CNT_EN
  logic [7:0]       frame_cnt;

  modport master (
    output en, in_valid,
    input  in_ready, bf_state, sr_en, tw_idx, out_valid, frame_done, frame_cnt
  );

  modport slave (
    input  en, in_valid,
    output in_ready, bf_state, sr_en, tw_idx, out_valid, frame_done, frame_cnt
  );
`else
  modport master (
    output en, in_valid,
    input  in_ready, bf_state, sr_en, tw_idx, out_valid, frame_done
  );

  modport slave (
    input  en, in_valid,
    output in_ready, bf_state, sr_en, tw_idx, out_valid, frame_done
  );
`endif

endinterface

// File: rtl/sdf_r2_stage_ctrl.sv
// -----------------------------------------------------------------------------
// sdf_r2_stage_ctrl
// Sequencer for one radix-2 single-path-delay-feedback FFT stage.
//
// One frame has three phases, each DEPTH counts long:
//   WAITING  DEPTH accepted samples are loaded into the delay line.
//   FIRST    DEPTH accepted samples. The butterfly emits sums and the delay
//            line takes differences.
//   SECOND   DEPTH cycles with no input. The stored differences drain out
//            with twiddle W^cnt.
// At the end of SECOND the controller samples en. If en=1 it starts the next
// frame in WAITING. If en=0 it goes to IDLE.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    sdf_r2_stage_ctrl_if.slave (en, in_valid -> in_ready, bf_state,
//          sr_en, tw_idx, out_valid, frame_done[, frame_cnt])
//
// Parameters:
//   DEPTH  delay-line length, a power of two and at least 2
//   IDX_W  counter / twiddle index width
//
// Build option:
//   SDF_CTRL_FRAME_CNT_EN  adds an 8-bit wrapping count of completed frames
//                          (bus.frame_cnt).
//
// bf_state is the state register itself, so it has no combinational path from
// the inputs. in_ready and out_valid are decoded from state and in_valid only.
// -----------------------------------------------------------------------------
module sdf_r2_stage_ctrl
  import fft_pkg::*;
#(
  parameter int DEPTH = STAGE_DEPTH_DEFAULT,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  sdf_r2_stage_ctrl_if.slave  bus
);

  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] CNT_ONE  = IDX_W'(1);

  stage_state_t     state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  logic             in_ready_w;
  logic             accept_w;
  logic             cnt_last_w;

  assign cnt_last_w = (cnt_q == CNT_LAST);
  assign accept_w   = bus.in_valid & in_ready_w;

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and counter logic
  // The counter returns to 0 on every state exit, so it never runs past
  // DEPTH-1.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.en) begin
          state_d = ST_WAITING;
          cnt_d   = '0;
        end
      end
      ST_WAITING, ST_FIRST: begin
        // A stall (no accept) freezes both the phase and the count.
        if (accept_w) begin
          if (cnt_last_w) begin
            state_d = (state_q == ST_WAITING) ? ST_FIRST : ST_SECOND;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
      end
      ST_SECOND: begin
        // The drain phase never stalls. en is sampled only on its last cycle,
        // so dropping en mid-frame still lets the frame finish.
        if (cnt_last_w) begin
          state_d = bus.en ? ST_WAITING : ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready_w     = 1'b0;
    bus.in_ready   = 1'b0;
    bus.sr_en      = 1'b0;
    bus.out_valid  = 1'b0;
    bus.tw_idx     = '0;
    bus.frame_done = 1'b0;
    bus.bf_state   = state_q;

    in_ready_w   = is_input_phase(state_q);
    bus.in_ready = in_ready_w;

    unique case (state_q)
      ST_WAITING: begin
        bus.sr_en = bus.in_valid;
      end
      ST_FIRST: begin
        // The butterfly is combinational, so the sum appears in the accept cycle.
        bus.sr_en     = bus.in_valid;
        bus.out_valid = bus.in_valid;
      end
      ST_SECOND: begin
        bus.sr_en      = 1'b1;
        bus.out_valid  = 1'b1;
        bus.tw_idx     = cnt_q;
        bus.frame_done = cnt_last_w;
      end
      default: begin
        bus.sr_en = 1'b0;
      end
    endcase
  end

`ifdef SDF_CTRL_FRAME_CNT_EN
  // ---------------------------------------------------------------------------
  // Completed-frame counter, wraps 255 -> 0.
  // ---------------------------------------------------------------------------
  logic [7:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if ((state_q == ST_SECOND) && cnt_last_w) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.frame_cnt = frame_cnt_q;
`endif

endmodule
